// File: rtl/cfg_loader_if.sv
// Serial config stream in, committed bitstream and status out.
// The loader takes the slave side; whoever feeds the stream takes the master side.
interface cfg_loader_if #(
  parameter int BITS = 116
);
  logic            cfg_din;
  logic            cfg_valid;
  logic            cfg_abort;
  logic [BITS-1:0] bitstream;
  logic            cfg_busy;
  logic            cfg_done;
  logic            cfg_err;
  logic            fabric_rst_n;

  modport slave (
    input  cfg_din, cfg_valid, cfg_abort,
    output bitstream, cfg_busy, cfg_done, cfg_err, fabric_rst_n
  );

  modport master (
    output cfg_din, cfg_valid, cfg_abort,
    input  bitstream, cfg_busy, cfg_done, cfg_err, fabric_rst_n
  );
endinterface

// File: rtl/cfg_loader.sv
// Serial config loader: sync hunt, payload shift, XOR-fold checksum, atomic commit
// of the payload to the fabric bitstream, with the fabric held while unconfigured.
module cfg_loader #(
  parameter int          BITS = 116,
  parameter logic [7:0]  SYNC = 8'hA5
) (
  input  logic      clk,
  input  logic      reset,
  cfg_loader_if.slave cfg
);
  localparam int CW = $clog2(BITS);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

  state_t          state;
  logic [7:0]      shreg;
  logic [7:0]      chk;
  logic [BITS-1:0] shadow;
  logic [BITS-1:0] bs;
  logic [CW-1:0]   cnt;
  logic            mism;
  logic            loaded;
  logic            done;
  logic            err;
  logic            frst;

  logic [7:0]      sh_n;
  logic            mis_n;

  assign sh_n  = {shreg[6:0], cfg.cfg_din};
  // Mismatch including the bit being accepted now, so the 8th bit counts.
  assign mis_n = mism | (cfg.cfg_din ^ chk[cnt[2:0]]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      shreg  <= '0;
      chk    <= '0;
      shadow <= '0;
      bs     <= '0;
      cnt    <= '0;
      mism   <= 1'b0;
      loaded <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      frst   <= 1'b0;
    end else begin
      done <= 1'b0;
      frst <= (state == IDLE) && loaded;
      unique case (state)
        IDLE: begin
          if (cfg.cfg_valid) begin
            shreg <= sh_n;
            if (sh_n == SYNC) begin
              state  <= LOAD;
              err    <= 1'b0;
              chk    <= '0;
              cnt    <= '0;
              shadow <= '0;
              mism   <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (cfg.cfg_abort) begin
            state <= IDLE;
            shreg <= '0;
          end else if (cfg.cfg_valid) begin
            shadow            <= {shadow[BITS-2:0], cfg.cfg_din};
            chk[cnt[2:0]]     <= chk[cnt[2:0]] ^ cfg.cfg_din;
            if (cnt == CW'(BITS-1)) begin
              state <= CHECK;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        CHECK: begin
          if (cfg.cfg_abort) begin
            state <= IDLE;
            shreg <= '0;
          end else if (cfg.cfg_valid) begin
            mism <= mis_n;
            if (cnt[2:0] == 3'd7) begin
              cnt <= '0;
              if (mis_n) begin
                err   <= 1'b1;
                state <= IDLE;
                shreg <= '0;
              end else begin
                state <= COMMIT;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        COMMIT: begin
          bs     <= shadow;
          loaded <= 1'b1;
          done   <= 1'b1;
          state  <= IDLE;
          shreg  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cfg.bitstream    = bs;
  assign cfg.cfg_busy     = (state == LOAD) || (state == CHECK) || (state == COMMIT);
  assign cfg.cfg_done     = done;
  assign cfg.cfg_err      = err;
  assign cfg.fabric_rst_n = frst;
endmodule

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
Configuration loader that sits directly upstream of the 3x3 fabric top. It receives a serial configuration stream, hunts for a sync word, then shifts in the payload and verifies an 8-bit XOR-fold checksum. On a good checksum it commits the payload atomically to the parallel bitstream bus that drives the fabric. The fabric is held in reset while no valid configuration is live and while a load is in progress.

Parameters:
BITS, 116, payload width; equals fabric bitstream width.
SYNC, 8'hA5, sync word; first received bit is the MSB.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
cfg_din  input  1  serial config data bit
cfg_valid  input  1  cfg_din is accepted on a rising clk when high
cfg_abort  input  1  synchronous abort; discards the current load
bitstream  output  BITS  committed configuration to the fabric
cfg_busy  output  1  high in LOAD, CHECK and COMMIT
cfg_done  output  1  one-cycle pulse on a successful commit
cfg_err  output  1  sticky checksum-failure flag
fabric_rst_n  output  1  active-low hold for the fabric

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; sync shreg=0; shadow=0; chk=0; counters=0.
  - Outputs: bitstream=0, cfg_busy=0, cfg_done=0, cfg_err=0, fabric_rst_n=0.
  - loaded flag=0.
- Bit acceptance: only on a rising clk with cfg_valid=1. Cycles with cfg_valid=0 change nothing.
- IDLE:
  - Each accepted bit shifts into an 8-bit shreg (new bit enters the LSB).
  - If the updated shreg equals SYNC: go to LOAD next cycle; clear cfg_err, chk and the bit counter; clear shadow.
  - Overlapping sync matches are allowed.
- LOAD:
  - Each accepted bit shifts into shadow from the LSB (shadow <= {shadow[BITS-2:0], bit}). The first payload bit therefore ends in bitstream[BITS-1].
  - chk[cnt mod 8] ^= bit, where cnt counts from 0.
  - After accepting payload bit BITS-1: go to CHECK, reset cnt.
- CHECK:
  - Accept 8 check bits. Check bit k (k=0 first) must equal chk[k].
  - Keep a mismatch flag, OR-accumulated.
  - On the 8th check bit, if no mismatch (including the 8th): go to COMMIT. Otherwise set cfg_err=1 and go to IDLE.
  - On the error path, bitstream and loaded are unchanged.
- COMMIT (exactly 1 cycle):
  - bitstream <= shadow; loaded <= 1.
  - cfg_done=1 for this cycle only.
  - Next state is IDLE.
- fabric_rst_n = (state==IDLE) && loaded, registered.
  - It drops to 0 the cycle after sync detect and returns to 1 the cycle after COMMIT.
  - After a checksum error it returns to 1 only if an earlier configuration was committed; the fabric reruns the old config.
- cfg_busy: combinational decode of state in {LOAD, CHECK, COMMIT}.
- cfg_abort=1 in LOAD or CHECK: go to IDLE next cycle. Shadow is discarded, bitstream is unchanged, cfg_err is not set, and any cfg_valid bit in that cycle is ignored.
- cfg_abort in IDLE or COMMIT: ignored. A commit is never interrupted.
- Sync hunting is suspended outside IDLE. shreg is cleared on entry to IDLE from any state.
- Asynchronous reset mid-load: all state returns to the reset values above, bitstream clears to 0, fabric is held (fabric_rst_n=0).
- Latency: the last check bit is accepted at edge N. cfg_done and the new bitstream appear after edge N+1. fabric_rst_n=1 after edge N+2.

Test Plan:
- Good load:
  - Stimulus: after reset, cfg_valid=1 stream: 0xA5, then 116 ones, then check bits 1,1,1,1,0,0,0,0.
  - Required: bitstream = all ones; cfg_done pulses once; fabric_rst_n goes 0 to 1; cfg_err=0.
- Bad checksum:
  - Stimulus: same stream with the last check bit flipped to 1.
  - Required: cfg_err=1; no cfg_done; bitstream stays all-ones from the previous load; fabric_rst_n returns to 1.
- Ordering:
  - Stimulus: payload = single 1 as the first bit, rest 0; check bits 1,0,0,0,0,0,0,0.
  - Required: bitstream = 1<<115 (bit 115 set only).
- Gapped valid and sync hunt:
  - Stimulus: leading bits 1,0,1,0,0,1,0,1,1 (sync ends at the 8th bit); random cfg_valid=0 gaps through the payload.
  - Required: same result as the gap-free stream; cfg_busy high from the cycle after the sync bit to the end of COMMIT.
- Abort:
  - Stimulus: cfg_abort=1 after 50 payload bits.
  - Required: IDLE next cycle; bitstream unchanged; cfg_err=0; a following full good frame commits normally.
- Async reset mid-CHECK:
  - Stimulus: reset=0 between clock edges.
  - Required: bitstream=0, fabric_rst_n=0, cfg_busy=0 immediately, without waiting for a clock edge.
